// File: rtl/pctl_pkg.sv
// Shared definitions for the I/O port controller blocks: port map,
// OCW2 EOI codes and the interrupt arbiter state encodings.
package pctl_pkg;

  localparam logic [15:0] PIC_CMD  = 16'h0020;
  localparam logic [15:0] PIC_DATA = 16'h0021;

  localparam logic [2:0] EOI_NONSPEC = 3'b001;
  localparam logic [2:0] EOI_SPEC    = 3'b011;

  typedef enum logic {
    IDLE,
    WAIT
  } arb_state_t;

  typedef enum logic [1:0] {
    INIT_NONE,
    INIT_ICW2,
    INIT_ICW3,
    INIT_ICW4
  } init_step_t;

endpackage

// File: rtl/prio_enc8.sv
// Lowest-set-bit encoder: bit 0 has the highest priority.
module prio_enc8 (
  input  logic [7:0] req,
  output logic [2:0] idx,
  output logic       valid
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    idx   = 3'd0;
    valid = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (req[i]) begin
        idx   = 3'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_arbiter.sv
// Cut-down 8259A: edge-latched requests, fixed priority with nesting through
// the in-service register, and a toggle handshake towards the CPU.
module irq_arbiter
  import pctl_pkg::*;
#(
  parameter logic [15:0] BASE_PORT    = PIC_CMD,
  parameter logic [7:0]  VECTOR_RESET = 8'h08
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        port_clk,
  input  logic [15:0] port,
  input  logic        port_w,
  input  logic [7:0]  port_o,
  output logic [7:0]  port_i,
  input  logic [7:0]  irq_in,
  output logic        intr,
  input  logic        intl,
  output logic [7:0]  irq,
  output logic        busy
);

  logic [7:0] irq_q_reg;
  logic [7:0] irr_reg, irr_next;
  logic [7:0] isr_reg, isr_next;
  logic [7:0] imr_reg;
  logic [7:0] base_reg;
  logic       read_isr_reg;
  logic       sngl_reg;
  logic       ic4_reg;
  init_step_t init_reg;
  arb_state_t state_reg, state_next;
  logic       intr_reg;
  logic [7:0] irq_reg;
  logic [2:0] sel_reg;
  logic [7:0] port_i_reg;

  logic [7:0] edges;
  logic [2:0] cand_idx, isr_idx;
  logic       cand_valid, isr_valid;
  logic       eligible;
  logic       issue, ack;

  logic cmd_hit, data_hit;
  logic wr_cmd, wr_data, rd_cmd, rd_data;
  logic icw1, ocw2, ocw3;

  assign edges = irq_in & ~irq_q_reg;

  prio_enc8 u_cand (
    .req   (irr_reg & ~imr_reg),
    .idx   (cand_idx),
    .valid (cand_valid)
  );

  prio_enc8 u_level (
    .req   (isr_reg),
    .idx   (isr_idx),
    .valid (isr_valid)
  );

  // A request may only interrupt a strictly lower-priority service routine.
  assign eligible = cand_valid && (!isr_valid || (cand_idx < isr_idx));

  assign cmd_hit  = port_clk && (port == BASE_PORT);
  assign data_hit = port_clk && (port == BASE_PORT + 16'd1);
  assign wr_cmd   = cmd_hit && port_w;
  assign wr_data  = data_hit && port_w;
  assign rd_cmd   = cmd_hit && !port_w;
  assign rd_data  = data_hit && !port_w;
  assign icw1     = wr_cmd && port_o[4];
  assign ocw2     = wr_cmd && (port_o[4:3] == 2'b00);
  assign ocw3     = wr_cmd && (port_o[4:3] == 2'b01);

  always_comb begin
    state_next = state_reg;
    issue      = 1'b0;
    ack        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (eligible) begin
          issue      = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (intl == intr_reg) begin
          ack        = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Fresh edges are applied last so they survive a same-cycle acknowledge.
  always_comb begin
    irr_next = irr_reg;
    if (icw1) irr_next = 8'h00;
    if (ack)  irr_next[sel_reg] = 1'b0;
    irr_next = irr_next | edges;
  end

  // Acknowledge set is applied after EOI so it wins on the same bit.
  always_comb begin
    isr_next = isr_reg;
    if (ocw2) begin
      if (port_o[7:5] == EOI_NONSPEC && isr_valid) isr_next[isr_idx] = 1'b0;
      else if (port_o[7:5] == EOI_SPEC)           isr_next[port_o[2:0]] = 1'b0;
    end
    if (ack)  isr_next[sel_reg] = 1'b1;
    if (icw1) isr_next = 8'h00;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      irq_q_reg    <= irq_in;
      irr_reg      <= 8'h00;
      isr_reg      <= 8'h00;
      imr_reg      <= 8'h00;
      base_reg     <= VECTOR_RESET;
      read_isr_reg <= 1'b0;
      sngl_reg     <= 1'b0;
      ic4_reg      <= 1'b0;
      init_reg     <= INIT_NONE;
      state_reg    <= IDLE;
      intr_reg     <= 1'b0;
      irq_reg      <= 8'h00;
      sel_reg      <= 3'd0;
      port_i_reg   <= 8'h00;
    end else begin
      irq_q_reg <= irq_in;
      irr_reg   <= irr_next;
      isr_reg   <= isr_next;
      state_reg <= state_next;

      if (issue) begin
        irq_reg  <= base_reg + {5'b00000, cand_idx};
        sel_reg  <= cand_idx;
        intr_reg <= ~intr_reg;
      end

      if (icw1) begin
        imr_reg  <= 8'h00;
        init_reg <= INIT_ICW2;
        sngl_reg <= port_o[1];
        ic4_reg  <= port_o[0];
      end else if (wr_data) begin
        case (init_reg)
          INIT_ICW2: begin
            base_reg <= {port_o[7:3], 3'b000};
            if (!sngl_reg)    init_reg <= INIT_ICW3;
            else if (ic4_reg) init_reg <= INIT_ICW4;
            else              init_reg <= INIT_NONE;
          end
          INIT_ICW3: init_reg <= ic4_reg ? INIT_ICW4 : INIT_NONE;
          INIT_ICW4: init_reg <= INIT_NONE;
          default:   imr_reg  <= port_o;
        endcase
      end

      if (ocw3 && port_o[1]) read_isr_reg <= port_o[0];

      if (rd_cmd)       port_i_reg <= read_isr_reg ? isr_reg : irr_reg;
      else if (rd_data) port_i_reg <= imr_reg;
    end
  end

  assign intr   = intr_reg;
  assign irq    = irq_reg;
  assign port_i = port_i_reg;
  assign busy   = intr_reg != intl;

endmodule

// File: doc/irq_arbiter.md
Name: irq_arbiter

Overview:
8-input priority interrupt controller, a cut-down 8259A. It replaces the two-line IRQ logic inside the I/O port controller.
- Latches rising edges from the timer, keyboard, SD and other sources.
- Arbitrates with fixed priority (IRQ0 highest) and supports nesting through an in-service register.
- Presents one vector at a time to the CPU over the toggle handshake (intr/intl).
- Is programmed through ports BASE_PORT (command) and BASE_PORT+1 (data) on the shared port bus.

Parameters:
- BASE_PORT, 16'h0020: command port address; data port is BASE_PORT+1.
- VECTOR_RESET, 8'h08: vector base after reset.

Ports:
- clock  in  1  CPU host clock.
- reset_n  in  1  synchronous active-low reset, sampled on posedge clock.
- port_clk  in  1  single-cycle port access strobe.
- port  in  16  port address.
- port_w  in  1  1 = write, 0 = read.
- port_o  in  8  data from CPU.
- port_i  out  8  read data to CPU; registered.
- irq_in  in  8  interrupt sources; level, rising edge = request.
- intr  out  1  request toggle to CPU.
- intl  in  1  CPU acknowledge toggle; CPU copies intr into intl when it takes the vector.
- irq  out  8  vector number; stable while a request is outstanding.
- busy  out  1  1 while a request is outstanding (intr != intl).

Behaviour:
Reset (reset_n=0 at posedge clock):
- irr=0, isr=0, imr=0, base=VECTOR_RESET.
- Read select = IRR. Init sequence idle.
- Output resets: intr=0, irq=0, port_i=0.
- Edge-detect register loads irq_in, so sources already high at reset generate no request.
- Reset applies even mid-handshake. The CPU must reset intl alongside.

Edge capture:
- For each bit, irq_in & ~irq_q sets irr[n], every cycle, including masked bits.
- Masking only blocks arbitration.

Arbitration:
- Candidate = lowest-numbered n with irr[n] & ~imr[n].
- The candidate is eligible only if n < lowest set bit of isr, or isr == 0.

FSM:
- IDLE: if a candidate is eligible, latch irq <= base + n (8-bit wrap), latch sel <= n, toggle intr, go to WAIT. Transition takes 1 cycle: vector visible on the same edge intr toggles.
- WAIT: hold irq and sel. When intl == intr: clear irr[sel], set isr[sel], go to IDLE. The next request can issue on the following cycle at the earliest.
- A new edge on bit sel in the same cycle as the acknowledge clear: set wins, irr[sel] stays 1.
- Writes to imr during WAIT do not cancel the outstanding request.

Port writes (port_clk & port_w):
- CMD, port_o[4]=1 (ICW1): imr=0, isr=0, irr=0. Init step = expect ICW2. Remember port_o[1] (SNGL) and port_o[0] (IC4).
- DATA, in the init sequence:
  - ICW2: base <= {port_o[7:3], 3'b000}.
  - Then ICW3, only if SNGL=0; ignored.
  - Then ICW4, only if IC4=1; ignored.
  - Then init step returns to idle.
- DATA, not in init: imr <= port_o.
- CMD, port_o[4:3]=00 (OCW2):
  - 001 in [7:5]: non-specific EOI, clears lowest set isr bit.
  - 011 in [7:5]: specific EOI, clears isr[port_o[2:0]].
  - Other codes: ignored.
- CMD, port_o[4:3]=01 (OCW3): if port_o[1], read select <= port_o[0] (0=IRR, 1=ISR).
- EOI in the same cycle as acknowledge set: both apply. If they hit the same bit, set wins.

Port reads (port_clk & ~port_w), port_i valid the cycle after the strobe:
- CMD: irr or isr per read select.
- DATA: imr.
- Other addresses: port_i holds its previous value.

Decomposition:
- Shared package pctl_pkg:
  - Port address constants (PIC_CMD, PIC_DATA).
  - OCW2 EOI codes (EOI_NONSPEC=3'b001, EOI_SPEC=3'b011).
  - FSM state enum {IDLE, WAIT}.
  - Init-step enum {INIT_NONE, INIT_ICW2, INIT_ICW3, INIT_ICW4}.
- One sub-module is natural: prio_enc8, combinational lowest-set-bit encoder giving index + valid flag. It is instantiated twice (candidate and isr level).

Test Plan:
1. Reset, write CMD 8'h11, DATA 8'h20, DATA 8'h00 (ICW3), DATA 8'h01 (ICW4), then pulse irq_in[0] -> intr toggles, irq=8'h20; echo intl -> isr=8'h01, irr=0; read CMD after OCW3 8'h0B -> port_i=8'h01.
2. Raise irq_in[3] and irq_in[1] in the same cycle (base 8'h08) -> irq=8'h09 first. After ack, no request for IRQ3 until CMD 8'h20 (non-specific EOI) -> then irq=8'h0B.
3. isr[2] set, pulse irq_in[5] -> no request. Pulse irq_in[0] -> nested request irq=base+0. Specific EOI 8'h62 clears isr[2] only.
4. DATA 8'h02 (mask IRQ1), pulse irq_in[1] -> irr=8'h02, intr unchanged. DATA 8'h00 -> request irq=base+1.
5. irq_in[4] held high across reset -> no request. Drop and re-raise -> one request. Reset asserted during WAIT -> intr=0, irr=isr=0, FSM in IDLE next cycle.
6. Edge on irq_in[sel] in the acknowledge cycle -> irr[sel] remains 1. After EOI, a second request for the same vector issues.
